// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory,
// presents them to decode through an output register backed by a one-entry skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state_q, state_d;
    logic        release_q, release_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        consume;
    logic        redirect_take;
    logic [31:0] redirect_aligned;
    logic [31:0] pc_inc;

    // Request and address come from registered state only, never from stall/redirect.
    assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign dbg_state   = state_q;

    assign consume          = instr_valid_q && !stall;
    assign redirect_take    = redirect_valid && (state_q != ST_IDLE);
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign pc_inc           = pc_q + 32'd4;

    always_comb begin
        state_d       = state_q;
        release_d     = 1'b1;
        pc_d          = pc_q;
        drop_addr_d   = drop_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;

        if (redirect_take) begin
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            skid_valid_d  = 1'b0;
            pc_d          = redirect_aligned;
        end

        case (state_q)
            ST_IDLE: begin
                // The first edge after reset release only arms the stage; fetching starts one cycle later.
                if (release_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_take) begin
                    if (!imem_ack) begin
                        drop_addr_d = pc_q;
                        state_d     = ST_DROP;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_inc;
                    if (!instr_valid_q || consume) begin
                        instr_valid_d = 1'b1;
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = ST_HOLD;
                    end
                end else if (consume) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                end
            end
            ST_HOLD: begin
                if (redirect_take) begin
                    state_d = ST_REQ;
                end else if (consume && skid_valid_q) begin
                    instr_valid_d = 1'b1;
                    instr_d       = skid_instr_q;
                    instr_pc_d    = skid_pc_q;
                    skid_valid_d  = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            ST_DROP: begin
                // The outstanding request is retired at its original address; its data is never used.
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            release_q     <= 1'b0;
            pc_q          <= RESET_PC_ALIGNED;
            drop_addr_q   <= RESET_PC_ALIGNED;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0000_0000;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            release_q     <= release_d;
            pc_q          <= pc_d;
            drop_addr_q   <= drop_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/skid, redirects, PC wrap and mid-run reset.
module tb_fetch_stage;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] XMASK  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [1:0]  dbg_state;

    int err_cnt = 0;
    int chk_cnt = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .dbg_state      (dbg_state)
    );

    // clock / memory model
    always #5 clk = ~clk;
    assign imem_rdata = imem_addr ^ XMASK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        tick(); tick();
        chk_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        chk_cnt++; if (instr !== NOP) begin err_cnt++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
        chk_cnt++; if (instr_pc !== 32'h0) begin err_cnt++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
        chk_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        chk_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_stream();
        rst = 1'b0;
        tick();
        chk_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL stream_idle_req got=%b exp=0", imem_req); end
        tick();
        chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL stream_first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
        chk_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_early_valid got=%b exp=0", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(i * 4);
            tick();
            chk_cnt++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin err_cnt++; $display("FAIL stream_pc%0d got=%b/%h exp=1/%h", i, instr_valid, instr_pc, exp_pc); end
            chk_cnt++; if (instr !== (exp_pc ^ XMASK)) begin err_cnt++; $display("FAIL stream_instr%0d got=%h exp=%h", i, instr, exp_pc ^ XMASK); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++; if (instr_pc !== 32'd12 || instr_valid !== 1'b1) begin err_cnt++; $display("FAIL stall_hold%0d got=%b/%h exp=1/c", i, instr_valid, instr_pc); end
            chk_cnt++; if (imem_req !== 1'b0 || dbg_state !== ST_HOLD) begin err_cnt++; $display("FAIL stall_req%0d got=%b/%0d exp=0/%0d", i, imem_req, dbg_state, ST_HOLD); end
        end
        stall = 1'b0;
        tick();
        chk_cnt++; if (instr_pc !== 32'd16 || instr !== (32'd16 ^ XMASK) || instr_valid !== 1'b1) begin err_cnt++; $display("FAIL stall_skid got=%b/%h/%h exp=1/10/%h", instr_valid, instr_pc, instr, 32'd16 ^ XMASK); end
        chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'd20) begin err_cnt++; $display("FAIL stall_resume_addr got=%b/%h exp=1/14", imem_req, imem_addr); end
        tick();
        chk_cnt++; if (instr_pc !== 32'd20) begin err_cnt++; $display("FAIL stall_next got=%h exp=14", instr_pc); end
        tick();
        chk_cnt++; if (instr_pc !== 32'd24) begin err_cnt++; $display("FAIL stall_next2 got=%h exp=18", instr_pc); end
    endtask

    task automatic test_redirect_drop();
        imem_ack = 1'b0;
        tick();
        chk_cnt++; if (instr_valid !== 1'b0 || instr !== NOP) begin err_cnt++; $display("FAIL drop_consume got=%b/%h exp=0/%h", instr_valid, instr, NOP); end
        chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'd28) begin err_cnt++; $display("FAIL drop_wait_addr got=%b/%h exp=1/1c", imem_req, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk_cnt++; if (dbg_state !== ST_DROP || imem_addr !== 32'd28) begin err_cnt++; $display("FAIL drop_enter got=%0d/%h exp=%0d/1c", dbg_state, imem_addr, ST_DROP); end
        tick(); tick();
        chk_cnt++; if (dbg_state !== ST_DROP || imem_addr !== 32'd28 || imem_req !== 1'b1) begin err_cnt++; $display("FAIL drop_stable got=%0d/%h/%b exp=%0d/1c/1", dbg_state, imem_addr, imem_req, ST_DROP); end
        imem_ack = 1'b1;
        tick();
        chk_cnt++; if (instr_valid !== 1'b0 || dbg_state !== ST_REQ) begin err_cnt++; $display("FAIL drop_discard got=%b/%0d exp=0/%0d", instr_valid, dbg_state, ST_REQ); end
        chk_cnt++; if (imem_addr !== 32'h100) begin err_cnt++; $display("FAIL drop_new_addr got=%h exp=100", imem_addr); end
        tick();
        chk_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'hA5A5_0100) begin err_cnt++; $display("FAIL drop_first got=%b/%h/%h exp=1/100/a5a50100", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_redirect_ack();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        chk_cnt++; if (instr_valid !== 1'b0 || instr !== NOP) begin err_cnt++; $display("FAIL rack_flush got=%b/%h exp=0/%h", instr_valid, instr, NOP); end
        chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin err_cnt++; $display("FAIL rack_addr got=%b/%h exp=1/200", imem_req, imem_addr); end
        tick();
        chk_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== 32'hA5A5_0200) begin err_cnt++; $display("FAIL rack_first got=%b/%h/%h exp=1/200/a5a50200", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [3];
        exp_pcs[0] = 32'hFFFF_FFF8; exp_pcs[1] = 32'hFFFF_FFFC; exp_pcs[2] = 32'h0000_0000;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        chk_cnt++; if (imem_addr !== 32'hFFFF_FFF8 || instr_valid !== 1'b0) begin err_cnt++; $display("FAIL wrap_addr got=%h/%b exp=fffffff8/0", imem_addr, instr_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++; if (instr_valid !== 1'b1 || instr_pc !== exp_pcs[i] || instr !== (exp_pcs[i] ^ XMASK)) begin err_cnt++; $display("FAIL wrap_pc%0d got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr_pc, instr, exp_pcs[i], exp_pcs[i] ^ XMASK); end
        end
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1;
        tick();
        chk_cnt++; if (dbg_state !== ST_HOLD || imem_req !== 1'b0 || instr_pc !== 32'h0) begin err_cnt++; $display("FAIL rhold_enter got=%0d/%b/%h exp=%0d/0/0", dbg_state, imem_req, instr_pc, ST_HOLD); end
        rst = 1'b1;
        #1;
        chk_cnt++; if (instr_valid !== 1'b0 || instr !== NOP || imem_req !== 1'b0) begin err_cnt++; $display("FAIL rhold_async got=%b/%h/%b exp=0/%h/0", instr_valid, instr, imem_req, NOP); end
        chk_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rhold_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        tick(); tick();
        chk_cnt++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin err_cnt++; $display("FAIL rhold_held got=%b/%b exp=0/0", imem_req, instr_valid); end
        rst = 1'b0; stall = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL rhold_idle_req got=%b exp=0", imem_req); end
        tick();
        chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL rhold_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
        tick();
        chk_cnt++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== XMASK) begin err_cnt++; $display("FAIL rhold_first got=%b/%h/%h exp=1/0/%h", instr_valid, instr_pc, instr, XMASK); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
